// File: rtl/ro_counter_pkg.sv
// Shared definitions for the ring-oscillator edge counter.
// Holds default parameter values and the default count word type.
package ro_counter_pkg;

    localparam int RO_M_DOUT_DEF = 16;
    localparam int RO_FRAC_W_DEF = 8;
    localparam int RO_INC_DEF    = 256;

    // Integer edge increment per cycle is 0..31, so 5 bits.
    localparam int RO_INC_INT_W  = 5;

    typedef logic [RO_M_DOUT_DEF-1:0] ro_count_t;

endpackage

// File: rtl/ro_counter_if.sv
// Monitor-facing bundle of one RO counter: window, select and count.
// master = process monitor (drives running/i_use), slave = counter.
interface ro_counter_if #(
    parameter int W = 16
);
    logic         running;
    logic         i_use;
    logic [W-1:0] count;

    modport master (
        output running,
        output i_use,
        input  count
    );

    modport slave (
        input  running,
        input  i_use,
        output count
    );

endinterface

// File: rtl/ro_counter_sat_adder.sv
// Saturating unsigned adder: y_o = min(a_i + b_i, 2^W - 1).
// Ports: a_i (W), b_i (IW), y_o (W), ovf_o = result pinned at all-ones.
module sat_adder #(
    parameter int W  = 16,
    parameter int IW = 5
) (
    input  logic [W-1:0]  a_i,
    input  logic [IW-1:0] b_i,
    output logic [W-1:0]  y_o,
    output logic          ovf_o
);

    // One bit wider than the wider operand so the carry is never lost.
    localparam int SW = (W + 1 > IW) ? W + 1 : IW + 1;

    logic [SW-1:0] a_w;
    logic [SW-1:0] b_w;
    logic [SW-1:0] sum_w;
    logic [SW-1:0] max_w;

    assign a_w   = {{(SW-W){1'b0}}, a_i};
    assign b_w   = {{(SW-IW){1'b0}}, b_i};
    assign max_w = {{(SW-W){1'b0}}, {W{1'b1}}};
    assign sum_w = a_w + b_w;

    assign ovf_o = (sum_w >= max_w);
    assign y_o   = (sum_w > max_w) ? {W{1'b1}} : sum_w[W-1:0];

endmodule

// File: rtl/ro_counter.sv
// Ring-oscillator edge counter modelled as a fixed-point edge rate.
// Ports: clk, rst (sync, active high), bus (slave: running, i_use -> count).
module ro_counter
    import ro_counter_pkg::*;
#(
    parameter int RO_M_DOUT = RO_M_DOUT_DEF,
    parameter int RO_FRAC_W = RO_FRAC_W_DEF,
    parameter int RO_INC    = RO_INC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ro_counter_if.slave  bus
);

    localparam int SUMW = RO_FRAC_W + RO_INC_INT_W;
    localparam logic [SUMW-1:0] INC_C = SUMW'(RO_INC);

    logic [RO_FRAC_W-1:0]    phase_q;
    logic [RO_FRAC_W-1:0]    phase_d;
    logic [RO_M_DOUT-1:0]    count_q;
    logic [RO_M_DOUT-1:0]    count_d;
    logic                    sat_q;
    logic                    sat_d;

    logic [SUMW-1:0]         sum;
    logic [RO_INC_INT_W-1:0] inc;
    logic [RO_M_DOUT-1:0]    add_y;
    logic                    add_ovf;

    // Whole edges fall out of the top of the phase accumulator.
    assign sum = {{RO_INC_INT_W{1'b0}}, phase_q} + INC_C;
    assign inc = sum[SUMW-1:RO_FRAC_W];

    sat_adder #(
        .W  (RO_M_DOUT),
        .IW (RO_INC_INT_W)
    ) u_sat_adder (
        .a_i   (count_q),
        .b_i   (inc),
        .y_o   (add_y),
        .ovf_o (add_ovf)
    );

    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (!bus.i_use) begin
            phase_d = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (bus.running) begin
            phase_d = sum[RO_FRAC_W-1:0];
            // Once pinned, stay at all-ones until cleared.
            count_d = sat_q ? {RO_M_DOUT{1'b1}} : add_y;
            sat_d   = sat_q | add_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_ro_counter.sv
// Directed self-checking bench for ro_counter.
// Four instances cover unit, fractional and saturating rates.
module tb_ro_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ro_counter_if #(.W(16)) b256 ();
    ro_counter_if #(.W(16)) b384 ();
    ro_counter_if #(.W(16)) b64  ();
    ro_counter_if #(.W(4))  bsat ();

    ro_counter #(.RO_M_DOUT(16), .RO_FRAC_W(8), .RO_INC(256)) dut256 (
        .clk (clk),
        .rst (rst),
        .bus (b256)
    );

    ro_counter #(.RO_M_DOUT(16), .RO_FRAC_W(8), .RO_INC(384)) dut384 (
        .clk (clk),
        .rst (rst),
        .bus (b384)
    );

    ro_counter #(.RO_M_DOUT(16), .RO_FRAC_W(8), .RO_INC(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    ro_counter #(.RO_M_DOUT(4), .RO_FRAC_W(8), .RO_INC(768)) dutsat (
        .clk (clk),
        .rst (rst),
        .bus (bsat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        b256.running = 1'b1;
        b256.i_use   = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b256.count !== 16'd0) begin
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, b256.count);
                errors++;
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (b256.count !== 16'(i)) begin
                $display("FAIL reset_release[%0d]: got %0d expected %0d", i, b256.count, i);
                errors++;
            end
        end
        b256.running = 1'b0;
    endtask

    task automatic test_window();
        b256.i_use   = 1'b1;
        b256.running = 1'b0;
        do_reset();
        b256.running = 1'b1;
        repeat (10) step();
        checks++;
        if (b256.count !== 16'd10) begin
            $display("FAIL window_open: got %0d expected 10", b256.count);
            errors++;
        end
        b256.running = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (b256.count !== 16'd10) begin
                $display("FAIL window_hold[%0d]: got %0d expected 10", i, b256.count);
                errors++;
            end
        end
        b256.running = 1'b1;
        repeat (4) step();
        checks++;
        if (b256.count !== 16'd14) begin
            $display("FAIL window_resume: got %0d expected 14", b256.count);
            errors++;
        end
        b256.running = 1'b0;
    endtask

    task automatic test_frac_1p5();
        int exp_v[4] = '{1, 3, 4, 6};
        b384.i_use   = 1'b1;
        b384.running = 1'b0;
        do_reset();
        b384.running = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (b384.count !== 16'(exp_v[i])) begin
                $display("FAIL frac_1p5[%0d]: got %0d expected %0d", i, b384.count, exp_v[i]);
                errors++;
            end
        end
        b384.running = 1'b0;
    endtask

    task automatic test_frac_0p25();
        b64.i_use   = 1'b1;
        b64.running = 1'b0;
        do_reset();
        b64.running = 1'b1;
        repeat (3) step();
        checks++;
        if (b64.count !== 16'd0) begin
            $display("FAIL frac_0p25_mid: got %0d expected 0", b64.count);
            errors++;
        end
        step();
        checks++;
        if (b64.count !== 16'd1) begin
            $display("FAIL frac_0p25_4: got %0d expected 1", b64.count);
            errors++;
        end
        repeat (4) step();
        checks++;
        if (b64.count !== 16'd2) begin
            $display("FAIL frac_0p25_8: got %0d expected 2", b64.count);
            errors++;
        end
        b64.running = 1'b0;
    endtask

    task automatic test_disable();
        b256.i_use   = 1'b1;
        b256.running = 1'b0;
        do_reset();
        b256.running = 1'b1;
        repeat (7) step();
        checks++;
        if (b256.count !== 16'd7) begin
            $display("FAIL disable_pre: got %0d expected 7", b256.count);
            errors++;
        end
        b256.i_use = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b256.count !== 16'd0) begin
                $display("FAIL disable_off[%0d]: got %0d expected 0", i, b256.count);
                errors++;
            end
        end
        b256.i_use = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (b256.count !== 16'(i)) begin
                $display("FAIL disable_restart[%0d]: got %0d expected %0d", i, b256.count, i);
                errors++;
            end
        end
        b256.running = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_v[6] = '{3, 6, 9, 12, 15, 15};
        bsat.i_use   = 1'b1;
        bsat.running = 1'b0;
        do_reset();
        bsat.running = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bsat.count !== 4'(exp_v[i])) begin
                $display("FAIL sat_ramp[%0d]: got %0d expected %0d", i, bsat.count, exp_v[i]);
                errors++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bsat.count !== 4'd15) begin
                $display("FAIL sat_hold[%0d]: got %0d expected 15", i, bsat.count);
                errors++;
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (bsat.count !== 4'd0) begin
            $display("FAIL sat_reset: got %0d expected 0", bsat.count);
            errors++;
        end
        rst = 1'b0;
        step();
        checks++;
        if (bsat.count !== 4'd3) begin
            $display("FAIL sat_after_reset: got %0d expected 3", bsat.count);
            errors++;
        end
        bsat.running = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b256.running = 1'b0;
        b256.i_use   = 1'b0;
        b384.running = 1'b0;
        b384.i_use   = 1'b0;
        b64.running  = 1'b0;
        b64.i_use    = 1'b0;
        bsat.running = 1'b0;
        bsat.i_use   = 1'b0;
        #1;
        step();
        test_reset();
        test_window();
        test_frac_1p5();
        test_frac_0p25();
        test_disable();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
